// File: rtl/minibus_master_port.sv
// Single-issue CPU load/store to minibus initiator: alignment check, store lane replication, load extract/extend.
// Optional `MINIBUS_MASTER_TIMEOUT_EN builds a BUS-phase timeout that returns err after TIMEOUT_CYCLES cycles.
module minibus_master_port #(
   parameter int unsigned BIT_WIDTH      = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req_valid,
   output logic                 cpu_req_ready,
   input  logic [BIT_WIDTH-1:0] cpu_addr,
   input  logic                 cpu_wen,
   input  logic [1:0]           cpu_width,
   input  logic                 cpu_unsigned,
   input  logic [BIT_WIDTH-1:0] cpu_wdata,
   output logic                 cpu_resp_valid,
   output logic [BIT_WIDTH-1:0] cpu_resp_rdata,
   output logic                 cpu_resp_err,
   output logic [BIT_WIDTH-1:0] bus_addr,
   output logic [BIT_WIDTH-1:0] bus_wdata,
   output logic                 bus_wen,
   output logic                 bus_ren,
   output logic [1:0]           bus_width,
   input  logic                 bus_ack,
   input  logic                 bus_err,
   input  logic [BIT_WIDTH-1:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t               state, state_nxt;
   logic                 uns_q, uns_nxt;
   logic [BIT_WIDTH-1:0] addr_nxt, wdata_nxt, rdata_nxt;
   logic [1:0]           width_nxt;
   logic                 wen_nxt, ren_nxt, rv_nxt, err_nxt;
   logic                 misaligned, timeout;
   logic [BIT_WIDTH-1:0] wdata_lanes, load_data;
   logic [7:0]           rd_byte;
   logic [15:0]          rd_half;

   assign cpu_req_ready = (state == IDLE);

   assign misaligned = (cpu_width == 2'b01 && cpu_addr[0]) ||
                       (cpu_width == 2'b10 && cpu_addr[1:0] != 2'b00) ||
                       (cpu_width == 2'b11);

   always_comb begin
      case (cpu_width)
         2'b00:   wdata_lanes = {(BIT_WIDTH/8){cpu_wdata[7:0]}};
         2'b01:   wdata_lanes = {(BIT_WIDTH/16){cpu_wdata[15:0]}};
         default: wdata_lanes = cpu_wdata;
      endcase
   end

   // Registered addr/width double as the lane selectors for the load result.
   assign rd_byte = bus_rdata[{bus_addr[1:0], 3'b000} +: 8];
   assign rd_half = bus_rdata[{bus_addr[1], 4'b0000} +: 16];

   always_comb begin
      case (bus_width)
         2'b00:   load_data = {{(BIT_WIDTH-8){rd_byte[7] & ~uns_q}}, rd_byte};
         2'b01:   load_data = {{(BIT_WIDTH-16){rd_half[15] & ~uns_q}}, rd_half};
         default: load_data = bus_rdata;
      endcase
   end

`ifdef MINIBUS_MASTER_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] cnt_q, cnt_nxt;

   assign timeout = (cnt_q == TO_LAST);
   assign cnt_nxt = (state == BUS) ? cnt_q + 8'd1 : '0;

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_nxt;
   end
`else
   assign timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      state_nxt = state;
      addr_nxt  = bus_addr;
      wdata_nxt = bus_wdata;
      width_nxt = bus_width;
      uns_nxt   = uns_q;
      wen_nxt   = 1'b0;
      ren_nxt   = 1'b0;
      rv_nxt    = 1'b0;
      err_nxt   = 1'b0;
      rdata_nxt = '0;
      case (state)
         IDLE: begin
            if (cpu_req_valid) begin
               addr_nxt  = cpu_addr;
               wdata_nxt = wdata_lanes;
               width_nxt = cpu_width;
               uns_nxt   = cpu_unsigned;
               if (misaligned) begin
                  rv_nxt    = 1'b1;
                  err_nxt   = 1'b1;
                  state_nxt = RESP;
               end else begin
                  wen_nxt   = cpu_wen;
                  ren_nxt   = ~cpu_wen;
                  state_nxt = BUS;
               end
            end
         end
         BUS: begin
            if (bus_err || timeout) begin
               rv_nxt    = 1'b1;
               err_nxt   = 1'b1;
               state_nxt = RESP;
            end else if (bus_ack) begin
               rv_nxt    = 1'b1;
               rdata_nxt = bus_ren ? load_data : '0;
               state_nxt = RESP;
            end else begin
               wen_nxt = bus_wen;
               ren_nxt = bus_ren;
            end
            // Ack in the same cycle as the timeout limit still counts as a response.
            if (bus_ack && !bus_err) begin
               err_nxt   = 1'b0;
               rdata_nxt = bus_ren ? load_data : '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         uns_q          <= 1'b0;
         bus_addr       <= '0;
         bus_wdata      <= '0;
         bus_width      <= '0;
         bus_wen        <= 1'b0;
         bus_ren        <= 1'b0;
         cpu_resp_valid <= 1'b0;
         cpu_resp_err   <= 1'b0;
         cpu_resp_rdata <= '0;
      end else begin
         state          <= state_nxt;
         uns_q          <= uns_nxt;
         bus_addr       <= addr_nxt;
         bus_wdata      <= wdata_nxt;
         bus_width      <= width_nxt;
         bus_wen        <= wen_nxt;
         bus_ren        <= ren_nxt;
         cpu_resp_valid <= rv_nxt;
         cpu_resp_err   <= err_nxt;
         cpu_resp_rdata <= rdata_nxt;
      end
   end

endmodule

// File: tb/tb_minibus_master_port.sv
// Bench for minibus_master_port: per-transaction expected timeline from the access rules, checked every cycle.
module tb_minibus_master_port;

`ifdef MINIBUS_MASTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
   localparam int TO    = 4;
`else
   localparam bit TO_EN = 1'b0;
   localparam int TO    = 255;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req_valid = 1'b0, cpu_req_ready;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        cpu_wen = 1'b0, cpu_unsigned = 1'b0;
   logic [1:0]  cpu_width = '0;
   logic        cpu_resp_valid, cpu_resp_err;
   logic [31:0] cpu_resp_rdata, bus_addr, bus_wdata;
   logic        bus_wen, bus_ren;
   logic [1:0]  bus_width;
   logic        bus_ack = 1'b0, bus_err = 1'b0;
   logic [31:0] bus_rdata = '0;

   minibus_master_port #(.BIT_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_addr(cpu_addr), .cpu_wen(cpu_wen), .cpu_width(cpu_width),
      .cpu_unsigned(cpu_unsigned), .cpu_wdata(cpu_wdata),
      .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_err(cpu_resp_err),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wen(bus_wen), .bus_ren(bus_ren),
      .bus_width(bus_width), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0, acc_cyc = 0, resp_cyc = 0;
   logic [31:0] last_rdata = '0, last_wdata = '0;
   logic        last_err = 1'b0;

   bit          chk_en = 1'b0;
   logic        exp_ready, exp_wen, exp_ren, exp_rv, exp_err;
   logic        exp_bus_chk, exp_wd_chk, exp_rsp_chk;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   logic [1:0]  exp_width;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [31:0] w, input logic [1:0] wd);
      if (wd == 2'd0) return {4{w[7:0]}};
      if (wd == 2'd1) return {2{w[15:0]}};
      return w;
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] wd, input logic u);
      logic [31:0] v, m, sbit;
      int lane;
      if (wd == 2'd2) return rd;
      lane = (wd == 2'd0) ? int'(a[1:0]) : 2 * int'(a[1]);
      v    = rd >> (8 * lane);
      m    = (wd == 2'd0) ? 32'hFF : 32'hFFFF;
      sbit = (wd == 2'd0) ? 32'h80 : 32'h8000;
      if (!u && (v & sbit) != 0) return v | ~m;
      return v & m;
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cpu_req_ready", 32'(cpu_req_ready), 32'(exp_ready));
         chk("cpu_resp_valid", 32'(cpu_resp_valid), 32'(exp_rv));
         chk("bus_wen", 32'(bus_wen), 32'(exp_wen));
         chk("bus_ren", 32'(bus_ren), 32'(exp_ren));
         if (exp_rsp_chk) begin
            chk("cpu_resp_rdata", cpu_resp_rdata, exp_rdata);
            chk("cpu_resp_err", 32'(cpu_resp_err), 32'(exp_err));
         end
         if (exp_bus_chk) begin
            chk("bus_addr", bus_addr, exp_addr);
            chk("bus_width", 32'(bus_width), 32'(exp_width));
         end
         if (exp_wd_chk) chk("bus_wdata", bus_wdata, exp_wdata);
      end
      if (cpu_resp_valid) begin
         last_rdata = cpu_resp_rdata;
         last_err   = cpu_resp_err;
         resp_cyc   = cyc;
      end
      if (bus_wen) last_wdata = bus_wdata;
   end

   task automatic set_idle();
      exp_ready = 1'b1; exp_wen = 1'b0; exp_ren = 1'b0; exp_rv = 1'b0;
      exp_bus_chk = 1'b0; exp_wd_chk = 1'b0; exp_rsp_chk = 1'b0;
   endtask

   task automatic set_zero();
      set_idle();
      exp_bus_chk = 1'b1; exp_wd_chk = 1'b1; exp_rsp_chk = 1'b1;
      exp_addr = '0; exp_width = '0; exp_wdata = '0; exp_rdata = '0; exp_err = 1'b0;
   endtask

   task automatic set_bus(input logic [31:0] a, input logic w, input logic [1:0] wd, input logic [31:0] wdat);
      exp_ready = 1'b0; exp_rv = 1'b0; exp_rsp_chk = 1'b0;
      exp_wen = w; exp_ren = !w;
      exp_bus_chk = 1'b1; exp_addr = a; exp_width = wd;
      exp_wd_chk = w; exp_wdata = lanes(wdat, wd);
   endtask

   task automatic set_resp(input logic [31:0] rd, input logic e);
      exp_ready = 1'b0; exp_wen = 1'b0; exp_ren = 1'b0; exp_rv = 1'b1;
      exp_bus_chk = 1'b0; exp_wd_chk = 1'b0; exp_rsp_chk = 1'b1;
      exp_rdata = rd; exp_err = e;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // kind: 0 = slave acks in BUS cycle lat, 1 = slave errors (ack maybe also high), 2 = slave silent
   task automatic run_access(input logic [31:0] a, input logic w, input logic [1:0] wd, input logic u,
                             input logic [31:0] wdat, input logic [31:0] rd, input int lat, input int kind);
      bit mis, to;
      int resp_at, last;
      cpu_req_valid = 1'b1; cpu_addr = a; cpu_wen = w; cpu_width = wd;
      cpu_unsigned = u; cpu_wdata = wdat;
      set_idle();
      acc_cyc = cyc;
      tick();
      cpu_req_valid = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
      cpu_width = 2'($urandom); cpu_wen = 1'($urandom); cpu_unsigned = 1'($urandom);
      mis = (wd == 2'd1 && a[0]) || (wd == 2'd2 && a[1:0] != 2'd0) || (wd == 2'd3);
      if (mis) begin
         set_resp('0, 1'b1);
         tick();
         set_idle();
         return;
      end
      resp_at = (kind == 2) ? 32'h3FFF_FFFF : lat;
      to      = TO_EN && (resp_at > TO);
      last    = to ? TO : resp_at;
      for (int c = 1; c <= last && c <= 2000; c++) begin
         set_bus(a, w, wd, wdat);
         if (c == resp_at) begin
            bus_rdata = rd;
            if (kind == 1) begin bus_err = 1'b1; bus_ack = 1'($urandom); end
            else bus_ack = 1'b1;
         end
         tick();
         bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      end
      set_resp((!to && kind == 0 && !w) ? extract(rd, a, wd, u) : 32'h0, to || kind == 1);
      tick();
      set_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      set_zero();
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      set_idle();
      tick();

      run_access(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 2, 0);
      chk("word_load_rdata", last_rdata, 32'hDEADBEEF);
      chk("word_load_latency", 32'(resp_cyc - acc_cyc), 32'd3);
      chk("word_load_err", 32'(last_err), 32'd0);

      run_access(32'h103, 1'b0, 2'd0, 1'b0, 32'h0, 32'h80112233, 2, 0);
      chk("sbyte_load_rdata", last_rdata, 32'hFFFFFF80);
      run_access(32'h103, 1'b0, 2'd0, 1'b1, 32'h0, 32'h80112233, 1, 0);
      chk("ubyte_load_rdata", last_rdata, 32'h00000080);
      run_access(32'h102, 1'b0, 2'd1, 1'b0, 32'h0, 32'h9ABC1234, 3, 0);
      chk("shalf_load_rdata", last_rdata, 32'hFFFF9ABC);

      run_access(32'h202, 1'b1, 2'd1, 1'b0, 32'h0000ABCD, 32'h0, 3, 0);
      chk("half_store_wdata", last_wdata, 32'hABCDABCD);
      chk("half_store_rdata", last_rdata, 32'h0);

      run_access(32'h101, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 2, 0);
      chk("misalign_latency", 32'(resp_cyc - acc_cyc), 32'd1);
      chk("misalign_err", 32'(last_err), 32'd1);
      chk("misalign_rdata", last_rdata, 32'h0);

      run_access(32'h300, 1'b0, 2'd2, 1'b0, 32'h0, 32'h12345678, 2, 1);
      chk("bus_err_flag", 32'(last_err), 32'd1);

`ifdef MINIBUS_MASTER_TIMEOUT_EN
      run_access(32'h304, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 2);
      chk("timeout_err", 32'(last_err), 32'd1);
      chk("timeout_latency", 32'(resp_cyc - acc_cyc), 32'd5);
`else
      run_access(32'h304, 1'b0, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 101, 0);
      chk("long_wait_rdata", last_rdata, 32'hCAFEF00D);
      chk("long_wait_latency", 32'(resp_cyc - acc_cyc), 32'd102);
`endif

      // Reset asserted during the first BUS cycle.
      cpu_req_valid = 1'b1; cpu_addr = 32'h400; cpu_wen = 1'b0; cpu_width = 2'd2; cpu_unsigned = 1'b0;
      set_idle();
      tick();
      cpu_req_valid = 1'b0;
      set_bus(32'h400, 1'b0, 2'd2, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_zero();
      tick();
      set_idle();
      tick();

      for (int i = 0; i < 200; i++) begin
         logic [31:0] a;
         int k;
         a = {20'h0, 12'($urandom)};
         k = ($urandom_range(0, 4) == 0) ? 1 : 0;
         run_access(a, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                    $urandom_range(1, 6), k);
         if ($urandom_range(0, 3) == 0) tick();
      end

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
